vga_capture: RTL and testbench

- Receive side of the VGA-style pixel interface: accepts an incoming RGB444 pixel stream framed by active-low vertical sync and data-enable.
- Windows the stream to the 512x256 frame buffer and emits write requests (we/waddr/wdata) into video memory.
- Lets the host or image coprocessor capture a full frame for processing.
- Host arms a capture; the block waits for the next frame start, stores one frame, then pulses done.

---
 rtl/vga_capture.sv | 198 +++++++++++++++++++
 tb/tb_vga_capture.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// -----------------------------------------------------------------------------
// vga_capture
//
// Receive side of the VGA-style pixel interface. Registers an incoming RGB444
// stream framed by active-low vertical sync and data enable, windows it to an
// X_LIM x Y_LIM frame buffer and issues write requests into video memory. The
// host arms a capture; the block waits for the next frame start (vsync falling
// edge), stores that one frame, then pulses done at the following frame start.
//
// Optional feature (macro VGA_CAPTURE_GRAY_EN):
//   defined   - wdata is grayscale g = (R + 2*G + B) >> 2, replicated {g,g,g}
//   undefined - wdata is the registered pixel unchanged
//
// Ports:
//   clk       in   system / pixel clock
//   rst_n     in   asynchronous active-low reset
//   arm       in   1-cycle request: capture the next complete frame
//   abort     in   cancel any capture in progress (wins over arm)
//   pix_vs_n  in   vertical sync, active low
//   pix_de    in   data enable, high during active pixels
//   pix_data  in   pixel {R[3:0], G[3:0], B[3:0]}
//   we        out  video memory write enable (1 cycle per stored pixel)
//   waddr     out  video memory write address, y*X_LIM + x
//   wdata     out  video memory write data
//   busy      out  high while waiting for frame start or capturing
//   done      out  1-cycle pulse at the end of a captured frame
//   ovf       out  sticky: an active pixel fell outside the stored window
// -----------------------------------------------------------------------------
module vga_capture #(
    parameter int X_LIM  = 512,
    parameter int Y_LIM  = 256,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic              pix_vs_n,
    input  logic              pix_de,
    input  logic [11:0]       pix_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [11:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    // Counters must be able to hold the limit itself, which is their
    // saturation value.
    localparam int XW = $clog2(X_LIM + 1);
    localparam int YW = $clog2(Y_LIM + 1);
    localparam logic [XW-1:0] X_MAX = XW'(X_LIM);
    localparam logic [YW-1:0] Y_MAX = YW'(Y_LIM);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } state_t;

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;

    logic            s_vs_n;
    logic            s_de;
    logic [11:0]     s_data;
    logic            p_vs_n;
    logic            p_de;

    logic            vs_fall;
    logic            de_fall;
    logic            in_win;
    logic [ADDR_W-1:0] pix_addr;
    logic [11:0]     pix_word;

    // -------------------------------------------------------------------------
    // Input stage: one register stage on the pixel bus plus a second stage on
    // the framing signals for edge detection.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vs_n <= 1'b1;
            s_de   <= 1'b0;
            s_data <= '0;
            p_vs_n <= 1'b1;
            p_de   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of its source; blocking here would collapse the
            // s_/p_ pipeline into a single stage.
            s_vs_n <= pix_vs_n;
            s_de   <= pix_de;
            s_data <= pix_data;
            p_vs_n <= s_vs_n;
            p_de   <= s_de;
        end
    end

    assign vs_fall = p_vs_n & ~s_vs_n;
    assign de_fall = p_de & ~s_de;

    // Saturated counters only gate writes; the address is never formed from
    // an out-of-window coordinate, so no wrap can reach memory.
    assign in_win   = (x < X_MAX) && (y < Y_MAX);
    assign pix_addr = ADDR_W'(y) * ADDR_W'(X_LIM) + ADDR_W'(x);

`ifdef VGA_CAPTURE_GRAY_EN
    // 6-bit sum (max 15 + 30 + 15 = 60) keeps the carry; >>2 gives 0..15.
    logic [3:0] gray;
    assign gray = 4'(({2'b00, s_data[11:8]}
                    + {1'b0, s_data[7:4], 1'b0}
                    + {2'b00, s_data[3:0]}) >> 2);
    assign pix_word = {gray, gray, gray};
`else
    assign pix_word = s_data;
`endif

    // busy is a pure decode of the state register.
    assign busy = (state == WAIT_VS) || (state == CAPTURE);

    // -------------------------------------------------------------------------
    // Capture FSM with registered write port and status outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;

            if (abort) begin
                // Drop everything; ovf is kept so the host can still read it.
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (arm) begin
                            state <= WAIT_VS;
                            ovf   <= 1'b0;
                        end
                    end

                    WAIT_VS: begin
                        if (vs_fall) begin
                            state <= CAPTURE;
                            x     <= '0;
                            y     <= '0;
                        end
                    end

                    CAPTURE: begin
                        // Frame boundary takes priority: that cycle's de is
                        // ignored and nothing is written.
                        if (vs_fall) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (s_de) begin
                            if (in_win) begin
                                we    <= 1'b1;
                                waddr <= pix_addr;
                                wdata <= pix_word;
                            end else begin
                                ovf <= 1'b1;
                            end
                            if (x != X_MAX) begin
                                x <= x + 1'b1;
                            end
                        end else if (de_fall) begin
                            x <= '0;
                            if (y != Y_MAX) begin
                                y <= y + 1'b1;
                            end
                        end
                    end

                    DONE: begin
                        state <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// -----------------------------------------------------------------------------
// tb_vga_capture
//
// Directed self-checking bench for vga_capture. Each scenario task drives
// frames through the pixel port and compares the logged write stream and
// status outputs with hand-derived expectations. Outputs are sampled 1 time
// unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_vga_capture;

    localparam int ADDR_W = 17;

    logic              clk;
    logic              rst_n;
    logic              arm;
    logic              abort;
    logic              pix_vs_n;
    logic              pix_de;
    logic [11:0]       pix_data;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [11:0]       wdata;
    logic              busy;
    logic              done;
    logic              ovf;

    int n_checks;
    int n_fail;
    int done_cnt;

    logic [ADDR_W-1:0] q_addr[$];
    logic [11:0]       q_data[$];

    vga_capture #(
        .X_LIM  (512),
        .Y_LIM  (256),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .abort    (abort),
        .pix_vs_n (pix_vs_n),
        .pix_de   (pix_de),
        .pix_data (pix_data),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected stored word for a given input pixel.
    function automatic logic [11:0] exp_data(input logic [11:0] d);
`ifdef VGA_CAPTURE_GRAY_EN
        int s;
        logic [3:0] g;
        s = (int'(d[11:8]) + 2 * int'(d[7:4]) + int'(d[3:0])) / 4;
        g = 4'(s);
        return {g, g, g};
`else
        return d;
`endif
    endfunction

    // One clock: apply inputs, pass the edge, log writes and done pulses.
    // arm/abort are one-cycle pulses and are cleared after every edge.
    task automatic step(input logic vs_n, input logic de, input logic [11:0] d);
        pix_vs_n = vs_n;
        pix_de   = de;
        pix_data = d;
        @(posedge clk);
        #1;
        if (we === 1'b1) begin
            q_addr.push_back(waddr);
            q_data.push_back(wdata);
        end
        if (done === 1'b1) done_cnt++;
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    task automatic vs_pulse();
        step(1'b0, 1'b0, 12'h000);
        step(1'b0, 1'b0, 12'h000);
        step(1'b1, 1'b0, 12'h000);
        step(1'b1, 1'b0, 12'h000);
        step(1'b1, 1'b0, 12'h000);
    endtask

    task automatic hblank();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 12'h000);
    endtask

    task automatic send_line(input int n, input logic [11:0] d);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, d);
        hblank();
    endtask

    task automatic send_frame(input int lines, input int ppl, input logic [11:0] d);
        vs_pulse();
        for (int l = 0; l < lines; l++) send_line(ppl, d);
        vs_pulse();
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        done_cnt = 0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step(1'b1, 1'b0, 12'h000);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (we !== 1'b0)    begin n_fail++; $display("FAIL reset_we: got %b want 0", we); end
        n_checks++; if (waddr !== '0)   begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
        n_checks++; if (wdata !== '0)   begin n_fail++; $display("FAIL reset_wdata: got %h want 000", wdata); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        #2 rst_n = 1'b1;
        step(1'b1, 1'b0, 12'h000);
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    // 3 lines x 4 pixels of 12'hABC.
    task automatic test_basic_frame();
        clear_log();
        do_arm();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_armed: got %b want 1", busy); end
        send_frame(3, 4, 12'hABC);
        n_checks++;
        if (q_addr.size() != 12) begin n_fail++; $display("FAIL basic_count: got %0d want 12", q_addr.size()); end
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < 4; p++) begin
                int k;
                k = l * 4 + p;
                if (k < q_addr.size()) begin
                    n_checks++;
                    if (q_addr[k] !== ADDR_W'(l * 512 + p)) begin
                        n_fail++;
                        $display("FAIL basic_addr[%0d]: got %0d want %0d", k, q_addr[k], l * 512 + p);
                    end
                    n_checks++;
                    if (q_data[k] !== exp_data(12'hABC)) begin
                        n_fail++;
                        $display("FAIL basic_data[%0d]: got %h want %h", k, q_data[k], exp_data(12'hABC));
                    end
                end
            end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        n_checks++; if (ovf !== 1'b0)  begin n_fail++; $display("FAIL basic_ovf: got %b want 0", ovf); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    endtask

    // One line of 520 pixels: only x = 0..511 stored, ovf raised.
    task automatic test_x_limit();
        clear_log();
        do_arm();
        send_frame(1, 520, 12'h5A5);
        n_checks++;
        if (q_addr.size() != 512) begin n_fail++; $display("FAIL xlim_count: got %0d want 512", q_addr.size()); end
        for (int k = 0; k < q_addr.size(); k++) begin
            n_checks++;
            if (q_addr[k] !== ADDR_W'(k)) begin
                n_fail++;
                $display("FAIL xlim_addr[%0d]: got %0d want %0d", k, q_addr[k], k);
            end
        end
        n_checks++; if (ovf !== 1'b1)   begin n_fail++; $display("FAIL xlim_ovf: got %b want 1", ovf); end
        n_checks++; if (done_cnt != 1)  begin n_fail++; $display("FAIL xlim_done: got %0d want 1", done_cnt); end
    endtask

    // Data present before any frame start must not be written.
    task automatic test_wait_vs();
        clear_log();
        arm = 1'b1;
        step(1'b1, 1'b1, 12'h111);
        // ovf from the previous capture is cleared by the arm.
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL waitvs_ovf_clear: got %b want 0", ovf); end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i % 8) < 5, 12'h111);
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL waitvs_busy[%0d]: got %b want 1", i, busy); end
        end
        n_checks++; if (q_addr.size() != 0) begin n_fail++; $display("FAIL waitvs_early_writes: got %0d want 0", q_addr.size()); end
        send_frame(1, 2, 12'h222);
        n_checks++;
        if (q_addr.size() != 2) begin
            n_fail++; $display("FAIL waitvs_count: got %0d want 2", q_addr.size());
        end else begin
            n_checks++;
            if (q_addr[0] !== 17'd0 || q_addr[1] !== 17'd1) begin
                n_fail++; $display("FAIL waitvs_addr: got %0d,%0d want 0,1", q_addr[0], q_addr[1]);
            end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL waitvs_done: got %0d want 1", done_cnt); end
    endtask

    // 258 one-pixel lines: lines 0..255 stored at y*512, last two overflow.
    task automatic test_y_limit();
        clear_log();
        do_arm();
        send_frame(258, 1, 12'h0F0);
        n_checks++;
        if (q_addr.size() != 256) begin n_fail++; $display("FAIL ylim_count: got %0d want 256", q_addr.size()); end
        for (int k = 0; k < q_addr.size(); k++) begin
            n_checks++;
            if (q_addr[k] !== ADDR_W'(k * 512)) begin
                n_fail++;
                $display("FAIL ylim_addr[%0d]: got %0d want %0d", k, q_addr[k], k * 512);
            end
        end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ylim_ovf: got %b want 1", ovf); end
    endtask

    // Distinct pixel values, including gray-path corner cases.
    task automatic test_data_values();
        logic [11:0] vals [4];
        vals[0] = 12'hF84;
        vals[1] = 12'hFFF;
        vals[2] = 12'h000;
        vals[3] = 12'h5A3;
        clear_log();
        do_arm();
        vs_pulse();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, vals[i]);
        hblank();
        vs_pulse();
        n_checks++;
        if (q_data.size() != 4) begin n_fail++; $display("FAIL data_count: got %0d want 4", q_data.size()); end
        for (int k = 0; k < q_data.size() && k < 4; k++) begin
            n_checks++;
            if (q_data[k] !== exp_data(vals[k])) begin
                n_fail++;
                $display("FAIL data_word[%0d]: got %h want %h", k, q_data[k], exp_data(vals[k]));
            end
        end
    endtask

    // abort rides with pixel 100: the write that pixel 99 would have made on
    // that same edge is suppressed, so pixels 0..98 are the only writes.
    task automatic test_abort();
        clear_log();
        do_arm();
        vs_pulse();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 12'(i));
        abort = 1'b1;
        step(1'b1, 1'b1, 12'(100));
        n_checks++; if (we !== 1'b0)   begin n_fail++; $display("FAIL abort_we: got %b want 0", we); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        for (int i = 101; i < 120; i++) step(1'b1, 1'b1, 12'(i));
        hblank();
        vs_pulse();
        n_checks++;
        if (q_addr.size() != 99) begin
            n_fail++; $display("FAIL abort_count: got %0d want 99", q_addr.size());
        end else begin
            n_checks++;
            if (q_addr[98] !== 17'd98 || q_data[98] !== exp_data(12'd98)) begin
                n_fail++; $display("FAIL abort_last: got %0d/%h want 98/%h", q_addr[98], q_data[98], exp_data(12'd98));
            end
        end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", done_cnt); end

        // Re-arm and capture a normal 2x3 frame.
        clear_log();
        do_arm();
        send_frame(2, 3, 12'h3C3);
        n_checks++;
        if (q_addr.size() != 6) begin
            n_fail++; $display("FAIL rearm_count: got %0d want 6", q_addr.size());
        end else begin
            n_checks++;
            if (q_addr[3] !== 17'd512 || q_addr[5] !== 17'd514) begin
                n_fail++; $display("FAIL rearm_addr: got %0d,%0d want 512,514", q_addr[3], q_addr[5]);
            end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rearm_done: got %0d want 1", done_cnt); end
    endtask

    // arm and abort together in IDLE: stay idle, capture nothing.
    task automatic test_arm_abort();
        clear_log();
        arm   = 1'b1;
        abort = 1'b1;
        step(1'b1, 1'b0, 12'h000);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL armabort_busy: got %b want 0", busy); end
        send_frame(1, 2, 12'h777);
        n_checks++; if (q_addr.size() != 0) begin n_fail++; $display("FAIL armabort_writes: got %0d want 0", q_addr.size()); end
        n_checks++; if (done_cnt != 0)      begin n_fail++; $display("FAIL armabort_done: got %0d want 0", done_cnt); end
    endtask

    // Asynchronous reset in the middle of a line.
    task automatic test_reset_mid();
        clear_log();
        do_arm();
        vs_pulse();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 12'h456);
        n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_we: got %b want 1", we); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (we !== 1'b0)   begin n_fail++; $display("FAIL rstmid_we: got %b want 0", we); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        clear_log();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 12'h456);
        hblank();
        vs_pulse();
        n_checks++; if (q_addr.size() != 0) begin n_fail++; $display("FAIL rstmid_writes: got %0d want 0", q_addr.size()); end
        n_checks++; if (done_cnt != 0)      begin n_fail++; $display("FAIL rstmid_done: got %0d want 0", done_cnt); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        done_cnt = 0;
        arm      = 1'b0;
        abort    = 1'b0;
        pix_vs_n = 1'b1;
        pix_de   = 1'b0;
        pix_data = 12'h000;
        rst_n    = 1'b0;

        test_reset();
        test_basic_frame();
        test_x_limit();
        test_wait_vs();
        test_y_limit();
        test_data_values();
        test_abort();
        test_arm_abort();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
